alu_cmd_driver: RTL
===================

Name: alu_cmd_driver

Overview:
Sequential initiator for the 8-bit combinational ALU (A, B, 4-bit select, 16-bit result, carry-out). It accepts operation commands over a valid/ready channel and drives the ALU operand/select inputs from registers. It waits a fixed settle time, captures the ALU result and carry, and returns them over a valid/ready response channel. It sits between a host/controller and the ALU instance, and replaces free-running stimulus with a handshaked, one-op-at-a-time interface.

Parameters:
SETTLE_CYCLES, 1, clock edges between loading ALU inputs and capturing ALU outputs; legal range 1..15.

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_a  in  8  operand A
cmd_b  in  8  operand B
cmd_sel  in  4  ALU select
sweep_start  in  1  one-cycle pulse: run all 16 selects (optional feature)
alu_a  out  8  to ALU A
alu_b  out  8  to ALU B
alu_sel  out  4  to ALU_Sel
alu_out  in  16  from ALU_Out
alu_carry  in  1  from CarryOut
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_out  out  16  captured ALU result
rsp_carry  out  1  captured carry
rsp_sel  out  4  select that produced this response
rsp_last  out  1  final response of a sweep
busy  out  1  state != IDLE
sweep_done  out  1  one-cycle pulse after the last sweep response is consumed

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - alu_a, alu_b, alu_sel, rsp_out, rsp_carry, rsp_sel = 0.
  - rsp_valid, rsp_last, busy, sweep_done = 0.
  - State = IDLE; settle counter = 0.
- Asserting rst_n low mid-operation aborts the operation immediately. Any pending response is discarded and no sweep_done is generated.
- FSM states: IDLE, SETTLE, RESP.
- cmd_ready is combinational: high iff state == IDLE.
- IDLE:
  - On a cmd_valid && cmd_ready edge: register cmd_a, cmd_b, cmd_sel into alu_a, alu_b, alu_sel; load counter = SETTLE_CYCLES-1; go to SETTLE.
  - If cmd_valid and sweep_start are both high in the same cycle, the command wins and sweep_start is dropped (not remembered).
  - sweep_start outside IDLE is ignored.
- SETTLE:
  - Counter != 0: decrement.
  - Counter == 0: capture alu_out into rsp_out, alu_carry into rsp_carry, alu_sel into rsp_sel; set rsp_valid = 1; go to RESP.
  - Latency: rsp_valid rises exactly SETTLE_CYCLES edges after the accepting edge.
- RESP:
  - rsp_out, rsp_carry, rsp_sel and rsp_last stay stable while rsp_valid && !rsp_ready.
  - On the handshake edge: clear rsp_valid and go to IDLE, or to the next sweep step.
  - Back-to-back throughput is one op per SETTLE_CYCLES+2 cycles; commands never overlap.
- alu_a, alu_b and alu_sel hold their last value in IDLE; they are not cleared.
- Width rules: operands pass through unmodified, any 4-bit select value is legal, and the 16-bit result is captured verbatim.

Optional Feature:
- Macro ALU_CMD_SWEEP_EN.
- Defined:
  - sweep_start in IDLE (with no cmd_valid) latches cmd_a and cmd_b as operands and issues selects 0,1,...,15 in sequence.
  - Each step takes the full SETTLE -> RESP path, using the same timing as a single command.
  - rsp_last = 1 on the sel=15 response only.
  - sweep_done pulses for one cycle on the edge after the sel=15 handshake, and the block is back in IDLE that cycle.
  - cmd_ready stays low for the whole sweep.
- Undefined:
  - sweep_start is ignored.
  - rsp_last and sweep_done are tied to 0.
  - Ports remain present.

Decomposition:
- Package alu_drv_pkg holds: state enum (IDLE, SETTLE, RESP); ALU_W = 8; ALU_RES_W = 16; ALU_SEL_W = 4; ALU_SEL_LAST = 4'hF.
- One sub-module, alu_rsp_reg: the response holding register with valid/ready (capture enable, hold, clear on handshake).
- FSM and counter stay in the top level.

Test Plan:
All scenarios use a bench ALU stub: alu_out = {alu_sel, 4'h0, alu_a ^ alu_b}, alu_carry = alu_sel[0].
- Reset: hold rst_n = 0 and drive random inputs -> all outputs 0, cmd_ready = 0 until rst_n rises, then cmd_ready = 1.
- Single op, SETTLE_CYCLES = 1: cmd a = 0xAA, b = 0x55, sel = 3, rsp_ready = 1 -> alu_a = 0xAA, alu_b = 0x55 after the accept edge; rsp_valid one edge later; rsp_out = 0x30FF, rsp_carry = 1, rsp_sel = 3.
- Backpressure: same command with rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_out = 0x30FF stable, cmd_ready = 0, busy = 1; a second cmd_valid is not accepted until the cycle after the handshake.
- Latency with SETTLE_CYCLES = 4: accept at edge N -> rsp_valid rises at edge N+4 exactly.
- Sweep (ALU_CMD_SWEEP_EN): sweep_start with cmd_a = 0xAA, cmd_b = 0x55, rsp_ready = 1 -> 16 responses, rsp_sel = 0..15, rsp_out = {sel, 0x0FF}, rsp_last only on sel = 15, then one sweep_done pulse; without the macro -> no activity.
- Reset mid-sweep: pull rst_n low during the sel = 7 SETTLE state -> rsp_valid = 0 immediately, no sweep_done; after release the block is in IDLE and a new command completes normally.

Source files
------------

// File: rtl/alu_drv_pkg.sv
// alu_drv_pkg: shared types and widths for the ALU command driver
package alu_drv_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  localparam int ALU_W = 8;
  localparam int ALU_RES_W = 16;
  localparam int ALU_SEL_W = 4;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_LAST = 4'hF;
endpackage

// File: rtl/alu_rsp_reg.sv
// alu_rsp_reg: response holding register; loads on cap, holds until the valid/ready handshake
module alu_rsp_reg
  import alu_drv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cap,
  input  logic [ALU_RES_W-1:0] d_out,
  input  logic                 d_carry,
  input  logic [ALU_SEL_W-1:0] d_sel,
  input  logic                 d_last,
  input  logic                 rsp_ready,
  output logic                 rsp_valid,
  output logic [ALU_RES_W-1:0] rsp_out,
  output logic                 rsp_carry,
  output logic [ALU_SEL_W-1:0] rsp_sel,
  output logic                 rsp_last
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_out   <= '0;
      rsp_carry <= 1'b0;
      rsp_sel   <= '0;
      rsp_last  <= 1'b0;
    end else if (cap) begin
      rsp_valid <= 1'b1;
      rsp_out   <= d_out;
      rsp_carry <= d_carry;
      rsp_sel   <= d_sel;
      rsp_last  <= d_last;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: handshaked one-op-at-a-time initiator for the combinational ALU
// Optional 16-select sweep enabled by defining ALU_CMD_SWEEP_EN.
module alu_cmd_driver
  import alu_drv_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ALU_W-1:0]     cmd_a,
  input  logic [ALU_W-1:0]     cmd_b,
  input  logic [ALU_SEL_W-1:0] cmd_sel,
  input  logic                 sweep_start,
  output logic [ALU_W-1:0]     alu_a,
  output logic [ALU_W-1:0]     alu_b,
  output logic [ALU_SEL_W-1:0] alu_sel,
  input  logic [ALU_RES_W-1:0] alu_out,
  input  logic                 alu_carry,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ALU_RES_W-1:0] rsp_out,
  output logic                 rsp_carry,
  output logic [ALU_SEL_W-1:0] rsp_sel,
  output logic                 rsp_last,
  output logic                 busy,
  output logic                 sweep_done
);
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [ALU_W-1:0] a_d, b_d;
  logic [ALU_SEL_W-1:0] sel_d;
  logic sweep, sweep_d, sweep_go, cap, done_d;
`ifdef ALU_CMD_SWEEP_EN
  assign sweep_go = sweep_start && !cmd_valid;
`else
  logic unused_sweep;
  assign unused_sweep = sweep_start;
  assign sweep_go = 1'b0;
`endif
  // rst_n gating keeps cmd_ready low for the whole reset assertion
  assign cmd_ready = rst_n && state == IDLE;
  assign busy = state != IDLE;
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sweep_d = sweep;
    a_d     = alu_a;
    b_d     = alu_b;
    sel_d   = alu_sel;
    cap     = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE: if (cmd_valid || sweep_go) begin
        state_d = SETTLE;
        cnt_d   = CNT_LOAD;
        a_d     = cmd_a;
        b_d     = cmd_b;
        sel_d   = cmd_valid ? cmd_sel : '0;
        sweep_d = sweep_go;
      end
      SETTLE: begin
        cnt_d   = cnt != 0 ? cnt - 1'b1 : cnt;
        cap     = cnt == 0;
        state_d = cnt == 0 ? RESP : SETTLE;
      end
      RESP: if (rsp_valid && rsp_ready) begin
        if (sweep && alu_sel != ALU_SEL_LAST) begin
          sel_d   = alu_sel + 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
          sweep_d = 1'b0;
          done_d  = sweep;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sweep      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      sweep_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      sweep      <= sweep_d;
      alu_a      <= a_d;
      alu_b      <= b_d;
      alu_sel    <= sel_d;
      sweep_done <= done_d;
    end
  end
  alu_rsp_reg u_rsp (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap       (cap),
    .d_out     (alu_out),
    .d_carry   (alu_carry),
    .d_sel     (alu_sel),
    .d_last    (sweep && alu_sel == ALU_SEL_LAST),
    .rsp_ready (rsp_ready),
    .rsp_valid (rsp_valid),
    .rsp_out   (rsp_out),
    .rsp_carry (rsp_carry),
    .rsp_sel   (rsp_sel),
    .rsp_last  (rsp_last)
  );
endmodule
